// File: rtl/sdes_pkg.sv
// Shared S-DES tables, bit-permutation helpers, S-box lookups and the sequencer state encoding.
// Table entries are 1-based bit positions counted from the MSB, as in the classic S-DES description.
package sdes_pkg;

  localparam int P10_TAB    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TAB     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_TAB     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IP_INV_TAB [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_TAB     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_TAB     [4]  = '{2, 4, 3, 1};

  // S-box contents flattened as row*4 + col.
  localparam logic [1:0] S0_TAB [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_ROUND1 = 3'd2,
    ST_ROUND2 = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [9:0] p10(input logic [9:0] v);
    logic [9:0] res;
    for (int i = 0; i < 10; i++) res[9 - i] = v[10 - P10_TAB[i]];
    return res;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] v);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) res[7 - i] = v[10 - P8_TAB[i]];
    return res;
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] v);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) res[7 - i] = v[8 - IP_TAB[i]];
    return res;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] v);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) res[7 - i] = v[8 - IP_INV_TAB[i]];
    return res;
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] v);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) res[7 - i] = v[4 - EP_TAB[i]];
    return res;
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] v);
    logic [3:0] res;
    for (int i = 0; i < 4; i++) res[3 - i] = v[4 - P4_TAB[i]];
    return res;
  endfunction

  // Row comes from the outer bits (b1,b4), column from the inner bits (b2,b3).
  function automatic logic [1:0] s0(input logic [3:0] x);
    return S0_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] x);
    return S1_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

endpackage

// File: rtl/get_keys.sv
// S-DES key schedule: P10, rotate halves by 1 -> P8 = K1, rotate by 2 more -> P8 = K2.
// enable=1 returns the pair in decrypt order (K2 on k1); the sequencer orders keys itself.
module get_keys
  import sdes_pkg::*;
(
  input  logic       enable,
  input  logic [9:0] q_in,
  output logic [7:0] k1,
  output logic [7:0] k2
);

  logic [9:0] perm;
  logic [9:0] ls1;
  logic [9:0] ls2;
  logic [7:0] k1_raw;
  logic [7:0] k2_raw;

  assign perm   = p10(q_in);
  assign ls1    = {perm[8:5], perm[9], perm[3:0], perm[4]};
  assign ls2    = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
  assign k1_raw = p8(ls1);
  assign k2_raw = p8(ls2);
  assign k1     = enable ? k2_raw : k1_raw;
  assign k2     = enable ? k1_raw : k2_raw;

endmodule

// File: rtl/sdes_fk.sv
// Combinational S-DES round function: L' = L ^ P4(S0/S1(EP(R) ^ k)).
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [3:0] l,
  input  logic [3:0] r,
  input  logic [7:0] k,
  output logic [3:0] l_out
);

  logic [7:0] mixed;
  logic [1:0] s0_out;
  logic [1:0] s1_out;

  assign mixed  = ep(r) ^ k;
  assign s0_out = s0(mixed[7:4]);
  assign s1_out = s1(mixed[3:0]);
  assign l_out  = l ^ p4({s0_out, s1_out});

endmodule

// File: rtl/sdes_ctrl.sv
// Sequencer for one S-DES block: key cache, KEYGEN, two time-shared fk rounds and the
// valid/ready handshakes toward the host and the result consumer.
module sdes_ctrl
  import sdes_pkg::*;
#(
  parameter int KEY_W     = 10,
  parameter int BLK_W     = 8,
  parameter int KEY_CACHE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic [BLK_W-1:0] data_in,
  input  logic             decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] data_out,
  output logic             busy
);

  state_t           state;
  state_t           next_state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] cache_key;
  logic             cache_valid;
  logic             dec_reg;
  logic [7:0]       k1;
  logic [7:0]       k2;
  logic [3:0]       l;
  logic [3:0]       r;
  logic [7:0]       gk_k1;
  logic [7:0]       gk_k2;
  logic [7:0]       round_key;
  logic [3:0]       fk_out;
  logic             use_k2;
  logic             cache_hit;
  logic             transfer;

  get_keys u_get_keys (
    .enable (1'b0),
    .q_in   (key_reg),
    .k1     (gk_k1),
    .k2     (gk_k2)
  );

  sdes_fk u_fk (
    .l     (l),
    .r     (r),
    .k     (round_key),
    .l_out (fk_out)
  );

  assign cache_hit = (KEY_CACHE != 0) && cache_valid && (key_in == cache_key);
  assign transfer  = in_valid && in_ready;
  assign round_key = use_k2 ? k2 : k1;

  // NOTE: nonblocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (in_valid) next_state = cache_hit ? ST_ROUND1 : ST_KEYGEN;
      ST_KEYGEN: next_state = ST_ROUND1;
      ST_ROUND1: next_state = ST_ROUND2;
      ST_ROUND2: next_state = ST_DONE;
      ST_DONE:   if (out_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Round 1 uses K1 for encrypt and K2 for decrypt; round 2 the other one.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    use_k2   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_ROUND1: use_k2 = dec_reg;
      ST_ROUND2: use_k2 = ~dec_reg;
      default: ;
    endcase
  end

  // NOTE: key material is reset too, so nothing from before a reset can be reused.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg     <= '0;
      dec_reg     <= 1'b0;
      cache_key   <= '0;
      cache_valid <= 1'b0;
      k1          <= '0;
      k2          <= '0;
      l           <= '0;
      r           <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (transfer) begin
            key_reg <= key_in;
            dec_reg <= decrypt;
            {l, r}  <= ip(data_in);
          end
        end
        ST_KEYGEN: begin
          k1          <= gk_k1;
          k2          <= gk_k2;
          cache_key   <= key_reg;
          cache_valid <= 1'b1;
        end
        // The SW swap is folded into this write.
        ST_ROUND1: begin
          l <= r;
          r <= fk_out;
        end
        ST_ROUND2: begin
          data_out  <= ip_inv({fk_out, r});
          out_valid <= 1'b1;
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_ctrl.sv
// Scoreboard bench for sdes_ctrl: directed vectors, backpressure, mid-round reset and
// randomized encrypt/decrypt pairs checked against an arithmetic S-DES reference.
module tb_sdes_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] key_in;
  logic [7:0] data_in;
  logic       decrypt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       busy;

  logic ready_fixed = 1'b1;
  logic rand_ready  = 1'b0;
  logic rand_bit    = 1'b1;

  assign out_ready = rand_ready ? rand_bit : ready_fixed;

  sdes_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_in    (key_in),
    .data_in   (data_in),
    .decrypt   (decrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) rand_bit <= 1'($urandom_range(0, 1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int S0_T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  // Positions are written as characters, 'A' meaning 10, MSB = position 1.
  function automatic int perm(input int v, input int w, input string tab);
    int res = 0;
    for (int i = 0; i < tab.len(); i++) begin
      int p = (tab[i] == "A") ? 10 : int'(tab[i]) - 48;
      res = (res << 1) | ((v >> (w - p)) & 1);
    end
    return res;
  endfunction

  function automatic int rotl5(input int x, input int n);
    return ((x << n) | (x >> (5 - n))) & 31;
  endfunction

  function automatic void key_sched(input int key, output int k1, output int k2);
    int p  = perm(key, 10, "35274A1986");
    int hl = rotl5(p >> 5, 1);
    int hr = rotl5(p & 31, 1);
    k1 = perm((hl << 5) | hr, 10, "637485A9");
    hl = rotl5(hl, 2);
    hr = rotl5(hr, 2);
    k2 = perm((hl << 5) | hr, 10, "637485A9");
  endfunction

  function automatic int f_fn(input int r4, input int k);
    int e  = perm(r4, 4, "41232341") ^ k;
    int a  = e >> 4;
    int b  = e & 15;
    int o0 = S0_T[((a >> 3) << 1) | (a & 1)][(a >> 1) & 3];
    int o1 = S1_T[((b >> 3) << 1) | (b & 1)][(b >> 1) & 3];
    return perm((o0 << 2) | o1, 4, "2431");
  endfunction

  function automatic logic [7:0] sdes_model(input logic [9:0] key, input logic [7:0] blk, input logic dec);
    int k1, k2, x, hl, hr, t;
    key_sched(int'(key), k1, k2);
    x  = perm(int'(blk), 8, "26314857");
    hl = x >> 4;
    hr = x & 15;
    hl = hl ^ f_fn(hr, dec ? k2 : k1);
    t  = hl;
    hl = hr;
    hr = t;
    hl = hl ^ f_fn(hr, dec ? k1 : k2);
    return 8'(perm((hl << 4) | hr, 8, "41357286"));
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    int         lat;
    int         xfer;
  } exp_t;

  exp_t       sb[$];
  logic       mdl_cache_valid = 1'b0;
  logic [9:0] mdl_cache_key   = '0;
  logic       prev_valid      = 1'b0;
  logic [7:0] held            = '0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h with nothing expected (cycle %0d)", data_out, cycle);
      end else begin
        e = sb.pop_front();
        check("data_out", int'(data_out), int'(e.data));
        check("latency", cycle - e.xfer, e.lat);
      end
      held = data_out;
    end else if (out_valid && prev_valid) begin
      check("hold_stable", int'(data_out), int'(held));
    end
    prev_valid = out_valid;
  end

  // Called on a negedge; returns on the negedge after the transfer edge.
  task automatic send(input logic [9:0] k, input logic [7:0] d, input logic dec, input logic [7:0] exp_data);
    exp_t e;
    int   waited = 0;
    key_in   = k;
    data_in  = d;
    decrypt  = dec;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    e.data = exp_data;
    e.lat  = (mdl_cache_valid && mdl_cache_key == k) ? 2 : 3;
    e.xfer = cycle + 1;
    sb.push_back(e);
    mdl_cache_valid = 1'b1;
    mdl_cache_key   = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, in_ready %0b, required 0 and 1", sb.size(), in_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [9:0] pool [4];
    logic [9:0] k;
    logic [7:0] x;
    logic [7:0] y;
    int         n;

    rst      = 1'b1;
    in_valid = 1'b0;
    key_in   = '0;
    data_in  = '0;
    decrypt  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_out_valid", int'(out_valid), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_in_ready", int'(in_ready), 1);

    // Classic encrypt vector, then its decrypt with a cached key.
    send(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    wait_drain();
    check("t1_k1", int'(dut.k1), int'(8'b10100100));
    check("t1_k2", int'(dut.k2), int'(8'b01000011));
    send(10'b1010000010, 8'b00111000, 1'b1, 8'b10010111);
    wait_drain();

    // Key schedule vectors.
    x = 8'($urandom);
    send(10'b1111100000, x, 1'b0, sdes_model(10'b1111100000, x, 1'b0));
    wait_drain();
    check("t3a_k1", int'(dut.k1), int'(8'b10010100));
    check("t3a_k2", int'(dut.k2), int'(8'b01010101));
    x = 8'($urandom);
    send(10'b1010101010, x, 1'b1, sdes_model(10'b1010101010, x, 1'b1));
    wait_drain();
    check("t3b_k1", int'(dut.k1), int'(8'b11100100));
    check("t3b_k2", int'(dut.k2), int'(8'b01010011));

    // Backpressure: result held, second request ignored.
    ready_fixed = 1'b0;
    send(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_out_valid", int'(out_valid), 1);
    key_in   = 10'h3c5;
    data_in  = 8'h5a;
    decrypt  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t4_stall_data", int'(data_out), int'(8'b00111000));
      check("t4_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid    = 1'b0;
    ready_fixed = 1'b1;
    @(negedge clk);
    check("t4_idle_in_ready", int'(in_ready), 1);
    check("t4_idle_out_valid", int'(out_valid), 0);

    // Reset while ROUND1 is in flight (cache hit goes straight there).
    send(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    check("t5_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mdl_cache_valid = 1'b0;
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_data_out", int'(data_out), 0);
    check("t5_in_ready", int'(in_ready), 1);
    send(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    wait_drain();

    // Randomized round trips with random consumer stalls.
    for (int i = 0; i < 4; i++) pool[i] = 10'($urandom);
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      k = pool[$urandom_range(0, 3)];
      x = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        y = sdes_model(k, x, 1'b0);
        send(k, x, 1'b0, y);
        send(k, y, 1'b1, x);
      end else begin
        y = sdes_model(k, x, 1'b1);
        send(k, x, 1'b1, y);
        send(k, y, 1'b0, x);
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
